// File: rtl/reg_list_sequencer.sv
// reg_list_sequencer
//
// Walks a 16-bit register list for a block transfer (LDM/STM). One selected
// register is moved per cycle, in ascending register number, with the
// memory word address stepping by 4. An optional base-register writeback
// cycle follows the transfers, and a one-cycle done pulse ends the operation.
//
// Build option:
//   REGFILE_XFER_WRITEBACK_EN - when defined, a WB cycle writes the final
//   address into register rn. The WB cycle is skipped for rn=15 and for an
//   LDM whose list contains rn. When undefined, wback and rn are ignored.
//
// Handshake: start is accepted only in IDLE, where busy=0. When it is
// accepted, every request input is captured on that clock edge. busy then
// stays high until the cycle after the done pulse. A start seen while busy
// is dropped and is not queued.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start                  request (sampled only in IDLE)
//   load, up, pre          LDM/STM, increment/decrement, before/after
//   wback, rn, base        writeback request, base register, base address
//   reg_list               bit i selects Ri
//   mem_read_data          async memory read data for mem_addr
//   read_datas             register file read data for read_reg_addrs
//   mem_addr               transfer word address
//   mem_write_enable/_data STM store strobe and data
//   read_reg_addrs         register being stored
//   write_enable3/_reg_addr3/_data3  register file write port
//   pc_write_enable/_data  LDM load of R15
//   busy, done             activity flag and completion pulse
module reg_list_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load,
  input  logic        up,
  input  logic        pre,
  input  logic        wback,
  input  logic [3:0]  rn,
  input  logic [31:0] base,
  input  logic [15:0] reg_list,
  input  logic [31:0] mem_read_data,
  input  logic [31:0] read_datas,
  output logic [31:0] mem_addr,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  output logic [3:0]  read_reg_addrs,
  output logic        write_enable3,
  output logic [3:0]  write_reg_addr3,
  output logic [31:0] write_data3,
  output logic        pc_write_enable,
  output logic [31:0] pc_write_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] cur_addr;   // address of the transfer in the current XFER cycle
  logic [15:0] pending;    // registers still to transfer
  logic        load_q;

  logic [4:0]  req_count;
  logic [31:0] span;       // 4 * popcount(reg_list)
  logic [31:0] start_addr;
  logic [3:0]  cur_reg;
  logic [15:0] pending_next;
  logic        go_wb;

  always_comb begin
    req_count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      req_count = req_count + {4'd0, reg_list[i]};
    end
  end

  assign span = {25'd0, req_count, 2'b00};

  // The lowest address of the block is always the first one transferred,
  // because registers go out in ascending order.
  always_comb begin
    case ({up, pre})
      2'b10:   start_addr = base;                  // IA
      2'b11:   start_addr = base + 32'd4;          // IB
      2'b00:   start_addr = base - span + 32'd4;   // DA
      default: start_addr = base - span;           // DB
    endcase
  end

  // The current register is the lowest register still pending.
  always_comb begin
    cur_reg = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) cur_reg = 4'(i);
    end
  end

  assign pending_next = pending & ~(16'd1 << cur_reg);

`ifdef REGFILE_XFER_WRITEBACK_EN
  logic        wb_q;
  logic [3:0]  rn_q;
  logic [31:0] final_q;
  logic [31:0] final_addr;
  logic        wb_applies;

  assign final_addr = up ? (base + span) : (base - span);
  // The loaded value wins over writeback. R15 is never written back.
  assign wb_applies = wback && (rn != 4'd15) && !(load && reg_list[rn]);
  assign go_wb      = wb_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{wback, rn};
  assign go_wb         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cur_addr <= 32'd0;
      pending  <= 16'd0;
      load_q   <= 1'b0;
`ifdef REGFILE_XFER_WRITEBACK_EN
      wb_q     <= 1'b0;
      rn_q     <= 4'd0;
      final_q  <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            load_q   <= load;
            pending  <= reg_list;
            cur_addr <= start_addr;
`ifdef REGFILE_XFER_WRITEBACK_EN
            wb_q     <= wb_applies;
            rn_q     <= rn;
            final_q  <= final_addr;
`endif
            state    <= (req_count != 5'd0) ? XFER : DONE;
          end
        end
        XFER: begin
          cur_addr <= cur_addr + 32'd4;
          pending  <= pending_next;
          if (pending_next == 16'd0) begin
            state <= go_wb ? WB : DONE;
          end
        end
        WB:      state <= DONE;
        default: state <= IDLE;   // DONE
      endcase
    end
  end

  // Address and strobes are decoded from registered state only. The data
  // outputs pass through combinationally because both data sources are
  // same-cycle reads.
  always_comb begin
    mem_addr         = 32'd0;
    mem_write_enable = 1'b0;
    mem_write_data   = 32'd0;
    read_reg_addrs   = 4'd0;
    write_enable3    = 1'b0;
    write_reg_addr3  = 4'd0;
    write_data3      = 32'd0;
    pc_write_enable  = 1'b0;
    pc_write_data    = 32'd0;
    busy             = (state != IDLE);
    done             = (state == DONE);
    case (state)
      XFER: begin
        mem_addr = cur_addr;
        if (load_q) begin
          if (cur_reg == 4'd15) begin
            pc_write_enable = 1'b1;
            pc_write_data   = mem_read_data;
          end else begin
            write_enable3   = 1'b1;
            write_reg_addr3 = cur_reg;
            write_data3     = mem_read_data;
          end
        end else begin
          read_reg_addrs   = cur_reg;
          mem_write_enable = 1'b1;
          mem_write_data   = read_datas;
        end
      end
`ifdef REGFILE_XFER_WRITEBACK_EN
      WB: begin
        write_enable3   = 1'b1;
        write_reg_addr3 = rn_q;
        write_data3     = final_q;
      end
`endif
      default: ;
    endcase
  end

endmodule
